// File: rtl/cen_gen_pkg.sv
// Shared definitions for the multi-channel fractional clock-enable generator.
package cen_gen_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } cen_state_t;

   localparam int MAX_CH = 8;

   // Channel-select width; a single channel still gets a 1-bit select port.
   function automatic int ch_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end
      return 1;
   endfunction

endpackage

// File: rtl/cen_frac_acc.sv
// One fractional-rate channel: accumulates num each running cycle and emits
// a registered enable whenever the running sum crosses den.
module cen_frac_acc
   import cen_gen_pkg::*;
#(
   parameter int               ACC_W   = 16,
   parameter logic [ACC_W-1:0] DEF_NUM = '0,
   parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(1)
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [ACC_W-1:0] load_num,
   input  logic [ACC_W-1:0] load_den,
   input  logic             run,
   output logic             cen
);

   logic [ACC_W-1:0] num_q;
   logic [ACC_W-1:0] den_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W:0]   sum;
   logic             wrap;

   // Next accumulator value; the carry decision uses one extra bit so acc+num
   // never overflows, and because acc < den the wrapped result always fits.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, num_q};
      wrap  = (sum >= {1'b0, den_q});
      acc_d = acc_q + num_q;
      if (wrap) begin
         acc_d = acc_q + num_q - den_q;
      end
   end

   // Ratio registers load on an accepted config; the accumulator and enable
   // only advance while the generator runs locked, otherwise they sit at zero.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         num_q <= DEF_NUM;
         den_q <= DEF_DEN;
         acc_q <= '0;
         cen   <= 1'b0;
      end else begin
         if (load) begin
            num_q <= load_num;
            den_q <= load_den;
         end
         if (run) begin
            acc_q <= acc_d;
            cen   <= wrap;
         end else begin
            acc_q <= '0;
            cen   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cen_gen_multi.sv
// Multi-channel fractional clock-enable generator running on refclk.
// Holds the lock/settle FSM, validates config writes and fans out to channels.
module cen_gen_multi
   import cen_gen_pkg::*;
#(
   parameter int                        NUM_CH      = 3,
   parameter int                        ACC_W       = 16,
   parameter int                        LOCK_CYCLES = 16,
   parameter logic [NUM_CH*ACC_W-1:0]   DEF_NUM     = {16'd24, 16'd12, 16'd6},
   parameter logic [NUM_CH*ACC_W-1:0]   DEF_DEN     = {3{16'd25}}
) (
   input  logic                      refclk,
   input  logic                      rst_n,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]          cfg_num,
   input  logic [ACC_W-1:0]          cfg_den,
   output logic                      cfg_err,
   output logic [NUM_CH-1:0]         cen,
   output logic                      locked
);

   localparam int               CH_W   = ch_w(NUM_CH);
   localparam int               CNT_W  = $clog2(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LOCK_CYCLES - 1);

   cen_state_t       state_q;
   cen_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cfg_bad;
   logic             cfg_take;
   logic             cfg_reject;
   logic             run;

   assign cfg_ready = (state_q != HOLD);
   assign locked    = (state_q == LOCKED);

   // Config validation: zero denominator, ratio above one, or a channel that
   // does not exist all reject the request without touching anything else.
   always_comb begin
      cfg_bad    = (cfg_den == '0) || (cfg_num > cfg_den) ||
                   ({{(32-CH_W){1'b0}}, cfg_ch} >= 32'(NUM_CH));
      cfg_take   = cfg_valid && cfg_ready && !cfg_bad;
      cfg_reject = cfg_valid && cfg_ready && cfg_bad;
   end

   // Lock sequencing: leave HOLD on the first clock, count out the settle time,
   // and restart the settle whenever a valid config lands. Channels run on the
   // cycle that will be locked so the first locked cycle already shows a step.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         HOLD: begin
            state_d = SETTLE;
            cnt_d   = RELOAD;
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = LOCKED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LOCKED: begin
            state_d = LOCKED;
         end
         default: begin
            state_d = HOLD;
         end
      endcase
      if (cfg_take) begin
         state_d = SETTLE;
         cnt_d   = RELOAD;
      end
      run = (state_d == LOCKED);
   end

   // FSM state, settle counter and the one-cycle reject pulse.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         cfg_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_err <= cfg_reject;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      cen_frac_acc #(
         .ACC_W   (ACC_W),
         .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
         .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
      ) u_acc (
         .refclk   (refclk),
         .rst_n    (rst_n),
         .load     (cfg_take && (cfg_ch == CH_W'(i))),
         .load_num (cfg_num),
         .load_den (cfg_den),
         .run      (run),
         .cen      (cen[i])
      );
   end

endmodule

// File: tb/tb_cen_gen_multi.sv
// Self-checking bench for cen_gen_multi: a cycle model built from rate
// arithmetic (pulse on locked cycle k iff floor(k*n/d) steps), a table of
// config writes, randomized config traffic and reset corner sequences.
module tb_cen_gen_multi;

   localparam int NUM_CH = 3;
   localparam int ACC_W  = 16;
   localparam int LOCK   = 16;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] num;
      logic [15:0] den;
      logic        exp_err;
   } cfg_vec_t;

   logic        refclk    = 1'b0;
   logic        rst_n     = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_ch    = '0;
   logic [15:0] cfg_num   = '0;
   logic [15:0] cfg_den   = '0;
   logic        cfg_ready;
   logic        cfg_err;
   logic [2:0]  cen;
   logic        locked;

   int     n_checks = 0;
   int     n_pass   = 0;

   bit     m_hold;
   int     m_since;
   bit     m_err;
   longint m_num [NUM_CH];
   longint m_den [NUM_CH];

   cfg_vec_t vecs [9];

   always #5 refclk = ~refclk;

   cen_gen_multi #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_num   (cfg_num),
      .cfg_den   (cfg_den),
      .cfg_err   (cfg_err),
      .cen       (cen),
      .locked    (locked)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic void model_reset();
      m_hold  = 1'b1;
      m_since = 0;
      m_err   = 1'b0;
      m_num   = '{6, 12, 24};
      m_den   = '{25, 25, 25};
   endfunction

   // Advance the model by one clock edge using the inputs held at that edge.
   function automatic void model_edge();
      bit take;
      bit bad;
      take = cfg_valid && !m_hold;
      bad  = (cfg_den == 16'd0) || (cfg_num > cfg_den) || (int'(cfg_ch) >= NUM_CH);
      m_err = take && bad;
      if (m_hold) begin
         m_hold  = 1'b0;
         m_since = 0;
      end else if (take && !bad) begin
         m_num[cfg_ch] = longint'(cfg_num);
         m_den[cfg_ch] = longint'(cfg_den);
         m_since       = 0;
      end else begin
         m_since++;
      end
   endfunction

   // Expected {cfg_ready, cfg_err, locked, cen} from rate arithmetic.
   function automatic logic [5:0] model_out();
      bit         lk;
      logic [2:0] c;
      longint     k;
      lk = !m_hold && (m_since >= LOCK);
      c  = '0;
      if (lk) begin
         k = longint'(m_since - LOCK + 1);
         for (int i = 0; i < NUM_CH; i++) begin
            c[i] = ((k * m_num[i]) / m_den[i]) != (((k - 1) * m_num[i]) / m_den[i]);
         end
      end
      return {!m_hold, m_err, lk, c};
   endfunction

   task automatic tick();
      @(posedge refclk);
      model_edge();
      #1;
      checkOutput("cycle", 64'({cfg_ready, cfg_err, locked, cen}), 64'(model_out()));
   endtask

   task automatic applyStimulus(input cfg_vec_t v);
      cfg_valid = 1'b1;
      cfg_ch    = v.ch;
      cfg_num   = v.num;
      cfg_den   = v.den;
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      while (!locked && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic do_reset();
      cfg_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      model_reset();
      checkOutput("reset_state", 64'({cfg_ready, cfg_err, locked, cen}), 64'd0);
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   // After a release: settle length, then pulse counts at the default ratios.
   task automatic check_defaults();
      int n;
      int c0;
      int c1;
      int c2;
      tick();
      checkOutput("ready_after_release", 64'(cfg_ready), 64'd1);
      wait_lock(n);
      checkOutput("lock_latency", 64'(n), 64'(LOCK));
      c0 = 0;
      c1 = 0;
      c2 = 0;
      repeat (250) begin
         c0 += int'(cen[0]);
         c1 += int'(cen[1]);
         c2 += int'(cen[2]);
         tick();
      end
      checkOutput("count_ch0", 64'(c0), 64'd60);
      checkOutput("count_ch1", 64'(c1), 64'd120);
      checkOutput("count_ch2", 64'(c2), 64'd240);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int       n;
      int       k;
      int       exp_k;
      cfg_vec_t v;

      vecs[0] = '{2'd0, 16'd3,     16'd7,     1'b0};
      vecs[1] = '{2'd1, 16'd3,     16'd7,     1'b0};
      vecs[2] = '{2'd2, 16'd1,     16'd4,     1'b0};
      vecs[3] = '{2'd0, 16'd1,     16'd0,     1'b1};
      vecs[4] = '{2'd1, 16'd5,     16'd4,     1'b1};
      vecs[5] = '{2'd3, 16'd1,     16'd2,     1'b1};
      vecs[6] = '{2'd0, 16'd1,     16'd1,     1'b0};
      vecs[7] = '{2'd1, 16'd0,     16'd5,     1'b0};
      vecs[8] = '{2'd2, 16'd65535, 16'd65535, 1'b0};

      #2;
      do_reset();
      check_defaults();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
         tick();
         cfg_valid = 1'b0;
         checkOutput("cfg_err", 64'(cfg_err), 64'(vecs[i].exp_err));
         checkOutput("locked_after_cfg", 64'(locked), 64'(vecs[i].exp_err));
         if (!vecs[i].exp_err) begin
            wait_lock(n);
            checkOutput("relock_latency", 64'(n), 64'(LOCK));
            if (vecs[i].num != 16'd0) begin
               k = 1;
               while (!cen[vecs[i].ch] && k < 200) begin
                  tick();
                  k++;
               end
               exp_k = (int'(vecs[i].den) + int'(vecs[i].num) - 1) / int'(vecs[i].num);
               checkOutput("first_pulse", 64'(k), 64'(exp_k));
            end
         end
         repeat (30) tick();
      end

      repeat (400) begin
         if ($urandom_range(0, 24) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_num   = 16'($urandom_range(0, 9));
            cfg_den   = 16'($urandom_range(0, 8));
         end else begin
            cfg_valid = 1'b0;
         end
         tick();
      end
      cfg_valid = 1'b0;
      repeat (20) tick();

      v = '{2'd0, 16'd1, 16'd3, 1'b0};
      applyStimulus(v);
      tick();
      cfg_valid = 1'b0;
      repeat (5) tick();
      checkOutput("locked_mid_settle", 64'(locked), 64'd0);
      do_reset();
      check_defaults();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
